// File: rtl/srlut_acc_norm_ctrl.sv
// SR-LUT accumulate-and-normalise sequencer: sums NUM_TERMS signed terms, rounds by 2^SHIFT, clamps to a pixel.
// Result is visible two cycles after the last term; OUT holds until out_ready, and in_ready stays low from NORM until the output handshake.
module srlut_acc_norm_ctrl #(
   parameter int DATA_W    = 32,
   parameter int NUM_TERMS = 4,
   parameter int SHIFT     = 4,
   parameter int OUT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_sat,
   output logic              busy
);

   localparam int ACC_W = DATA_W + $clog2(NUM_TERMS) + 1;
   localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
   // Normaliser width leaves at least one bit above the pixel range for the overflow test.
   localparam int QW    = (ACC_W + 1 > OUT_W + 2) ? ACC_W + 1 : OUT_W + 2;

   localparam logic [CNT_W-1:0]     LAST    = CNT_W'(NUM_TERMS - 1);
   localparam logic signed [QW-1:0] HALF    = QW'(2 ** (SHIFT - 1));
   localparam logic [OUT_W-1:0]     PIX_MAX = '1;

   typedef enum logic [1:0] {
      ACC  = 2'd0,
      NORM = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic signed [ACC_W-1:0]  acc, acc_nxt;
   logic                     out_valid_nxt;
   logic [OUT_W-1:0]         out_data_nxt;
   logic                     out_sat_nxt;

   logic signed [ACC_W-1:0]  term_ext;
   logic signed [QW-1:0]     rnd_sum;
   logic signed [QW-1:0]     q;
   logic                     q_neg;
   logic                     q_over;

   assign term_ext = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
   assign rnd_sum  = {{(QW - ACC_W){acc[ACC_W-1]}}, acc} + HALF;
   assign q        = rnd_sum >>> SHIFT;
   assign q_neg    = q[QW-1];
   assign q_over   = !q[QW-1] && (|q[QW-2:OUT_W]);

   assign busy = !((state == ACC) && (cnt == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACC;
         cnt       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         acc       <= acc_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
         out_sat   <= out_sat_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      acc_nxt       = acc;
      out_valid_nxt = out_valid;
      out_data_nxt  = out_data;
      out_sat_nxt   = out_sat;
      in_ready      = 1'b0;

      if (flush) begin
         // out_data deliberately keeps its last value across a flush.
         state_nxt     = ACC;
         cnt_nxt       = '0;
         acc_nxt       = '0;
         out_valid_nxt = 1'b0;
         out_sat_nxt   = 1'b0;
      end else begin
         case (state)
            ACC: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  acc_nxt = ((cnt == '0) ? '0 : acc) + term_ext;
                  if (cnt == LAST) begin
                     cnt_nxt   = '0;
                     state_nxt = NORM;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            NORM: begin
               if (q_neg) begin
                  out_data_nxt = '0;
                  out_sat_nxt  = 1'b1;
               end else if (q_over) begin
                  out_data_nxt = PIX_MAX;
                  out_sat_nxt  = 1'b1;
               end else begin
                  out_data_nxt = q[OUT_W-1:0];
                  out_sat_nxt  = 1'b0;
               end
               out_valid_nxt = 1'b1;
               state_nxt     = OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_nxt = 1'b0;
                  acc_nxt       = '0;
                  state_nxt     = ACC;
               end
            end
            default: begin
               state_nxt = ACC;
               cnt_nxt   = '0;
               acc_nxt   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_srlut_acc_norm_ctrl.sv
// Scoreboard bench for srlut_acc_norm_ctrl: directed pixels with hand-computed results.
module tb_srlut_acc_norm_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        out_sat;
   logic        busy;

   int checks = 0;
   int failures = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   srlut_acc_norm_ctrl #(.DATA_W(32), .NUM_TERMS(4), .SHIFT(4), .OUT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compares every output handshake against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_ready && out_valid) begin
            failures++;
            $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1 required not both");
         end
         if (out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got data=%0d sat=%0d expected no output", out_data, out_sat);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
               chk("out_sat", {31'd0, out_sat}, {31'd0, e[8]});
            end
         end
      end
   end

   task automatic send(input logic [31:0] d);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready stayed 0 expected 1 within 50 cycles");
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic px(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                     input logic [31:0] d, input logic [7:0] ed, input logic es, input bit push);
      if (push) exp_q.push_back({es, ed});
      send(a); send(b); send(c); send(d);
   endtask

   task automatic wait_ov();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL wait_out_valid: out_valid stayed 0 expected 1 within 20 cycles");
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #3;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      cycle();

      // Basic pixel with latency check
      px(100, 200, 300, 400, 8'd63, 1'b0, 1'b1);
      chk("lat_t1_out_valid", {31'd0, out_valid}, 32'd0);
      chk("lat_t1_busy", {31'd0, busy}, 32'd1);
      cycle();
      chk("lat_t2_out_valid", {31'd0, out_valid}, 32'd1);

      // Rounding and clamping
      px(6, 6, 6, 6, 8'd2, 1'b0, 1'b1);
      px(0, 0, 0, 7, 8'd0, 1'b0, 1'b1);
      px(-8, -8, 0, 7, 8'd0, 1'b1, 1'b1);
      px(-6, -6, -6, -6, 8'd0, 1'b1, 1'b1);
      px(4096, 4096, 4096, 4096, 8'd255, 1'b1, 1'b1);
      px(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 8'd255, 1'b1, 1'b1);
      wait_ov();
      cycle();

      // Backpressure
      out_ready = 1'b0;
      px(10, 20, 30, 40, 8'd6, 1'b0, 1'b1);
      wait_ov();
      cycle();
      in_valid = 1'b1;
      in_data  = 1000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_out_data", {24'd0, out_data}, 32'd6);
         chk("bp_out_sat", {31'd0, out_sat}, 32'd0);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         cycle();
      end
      out_ready = 1'b1;
      cycle();
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      px(1000, 1000, 1000, 1000, 8'd250, 1'b0, 1'b1);
      wait_ov();
      cycle();

      // Flush mid-accumulation
      send(5);
      send(7);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 99;
      #1;
      chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      px(16, 16, 16, 16, 8'd4, 1'b0, 1'b1);
      wait_ov();
      cycle();

      // Flush while holding a result
      out_ready = 1'b0;
      px(100, 100, 100, 100, 8'd25, 1'b0, 1'b0);
      wait_ov();
      cycle();
      flush     = 1'b1;
      out_ready = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_out_data_hold", {24'd0, out_data}, 32'd25);
      chk("flush_out_sat", {31'd0, out_sat}, 32'd0);

      // Asynchronous reset mid-ACC
      send(3);
      send(4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_acc_busy", {31'd0, busy}, 32'd0);
      chk("arst_acc_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_acc_out_data", {24'd0, out_data}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // Asynchronous reset mid-OUT
      out_ready = 1'b0;
      px(4096, 4096, 4096, 4096, 8'd255, 1'b1, 1'b0);
      wait_ov();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_out_data", {24'd0, out_data}, 32'd0);
      chk("arst_out_sat", {31'd0, out_sat}, 32'd0);
      chk("arst_out_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      cycle();
      px(100, 200, 300, 400, 8'd63, 1'b0, 1'b1);
      wait_ov();
      repeat (3) cycle();

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
